// File: rtl/ti_pkg.sv
// Shared definitions for the three-share threshold-implementation S-box datapath.
package ti_pkg;

  localparam int NIB_W   = 4;
  localparam int NSHARES = 3;
  localparam int PAIR_W  = (NSHARES - 1) * NIB_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  // Higher-index share always lands in the upper nibble of a share-pair bus.
  function automatic logic [PAIR_W-1:0] pack_pair(input logic [NIB_W-1:0] hi,
                                                  input logic [NIB_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ti_share_split.sv
// Combinational Boolean three-way split of a nibble using two random masks.
module ti_share_split
  import ti_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] m0,
  input  logic [NIB_W-1:0] m1,
  output logic [NIB_W-1:0] s0,
  output logic [NIB_W-1:0] s1,
  output logic [NIB_W-1:0] s2
);

  assign s0 = m0;
  assign s1 = m1;
  assign s2 = x ^ m0 ^ m1;

endmodule

// File: rtl/ti_share_gen.sv
// Masking front end: captures a nibble, pulls fresh randomness and presents three
// non-complete share-pair buses with a ready/valid handshake.
module ti_share_gen #(
  parameter int NIB_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NIB_W-1:0]   din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [2*NIB_W-1:0] rnd,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [2*NIB_W-1:0] sh_f0,
  output logic [2*NIB_W-1:0] sh_f1,
  output logic [2*NIB_W-1:0] sh_f2,
  output logic               sh_valid,
  input  logic               sh_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   sh_cnt
);

  import ti_pkg::*;

  state_t           state;
  logic [NIB_W-1:0] x_q;
  logic [NIB_W-1:0] s0, s1, s2;

  ti_share_split u_split (
    .x  (x_q),
    .m0 (rnd[NIB_W-1:0]),
    .m1 (rnd[2*NIB_W-1:NIB_W]),
    .s0 (s0),
    .s1 (s1),
    .s2 (s2)
  );

  // Accepting in PRESENT depends on the same-cycle downstream handshake.
  assign din_ready = (state == IDLE) || ((state == PRESENT) && sh_ready);

  // x_q is wiped as soon as its shares are loaded so the raw nibble lives one stage only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      sh_f0     <= '0;
      sh_f1     <= '0;
      sh_f2     <= '0;
      sh_valid  <= 1'b0;
      rnd_ready <= 1'b0;
      busy      <= 1'b0;
      sh_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            x_q       <= din;
            state     <= FETCH;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (rnd_valid) begin
            sh_f0     <= pack_pair(s2, s1);
            sh_f1     <= pack_pair(s2, s0);
            sh_f2     <= pack_pair(s1, s0);
            x_q       <= '0;
            state     <= PRESENT;
            rnd_ready <= 1'b0;
            sh_valid  <= 1'b1;
          end
        end
        PRESENT: begin
          if (sh_ready) begin
            sh_cnt   <= sh_cnt + CNT_W'(1);
            sh_valid <= 1'b0;
            if (din_valid) begin
              x_q       <= din;
              state     <= FETCH;
              rnd_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rnd_ready <= 1'b0;
          sh_valid  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ti_share_gen.sv
// Directed self-checking bench for ti_share_gen, with a narrow-counter twin for wrap checks.
module tb_ti_share_gen;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic [7:0] rnd;
  logic       rnd_valid;
  logic       sh_ready;

  logic        din_ready, rnd_ready, sh_valid, busy;
  logic [7:0]  sh_f0, sh_f1, sh_f2;
  logic [15:0] sh_cnt;

  logic        din_ready4, rnd_ready4, sh_valid4, busy4;
  logic [7:0]  sh_f0_4, sh_f1_4, sh_f2_4;
  logic [3:0]  sh_cnt4;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int rr_count = 0;

  ti_share_gen #(.NIB_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sh_f0(sh_f0), .sh_f1(sh_f1), .sh_f2(sh_f2), .sh_valid(sh_valid),
    .sh_ready(sh_ready), .busy(busy), .sh_cnt(sh_cnt)
  );

  ti_share_gen #(.NIB_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready4),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready4),
    .sh_f0(sh_f0_4), .sh_f1(sh_f1_4), .sh_f2(sh_f2_4), .sh_valid(sh_valid4),
    .sh_ready(sh_ready), .busy(busy4), .sh_cnt(sh_cnt4)
  );

  always #5 clk = ~clk;

  // Reference split: buses {s2,s1}, {s2,s0}, {s1,s0} concatenated f0|f1|f2.
  function automatic logic [23:0] model(input logic [3:0] x, input logic [7:0] r);
    logic [3:0] m0, m1, s2;
    m0 = r[3:0];
    m1 = r[7:4];
    s2 = x ^ m0 ^ m1;
    return {s2, m1, s2, m0, m1, m0};
  endfunction

  task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic rv,
                               input logic [7:0] r, input logic sr);
    din_valid = dv;
    din       = d;
    rnd_valid = rv;
    rnd       = r;
    sh_ready  = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] x;
    logic [7:0] r;
    logic [23:0] m;

    clk = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_f0", sh_f0, 0);
    checkOutput("rst_f1", sh_f1, 0);
    checkOutput("rst_f2", sh_f2, 0);
    checkOutput("rst_valid", sh_valid, 0);
    checkOutput("rst_rnd_ready", rnd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", sh_cnt, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_din_ready", din_ready, 1);

    $display("[TB] basic split x=A rnd=3C");
    applyStimulus(1'b1, 4'hA, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("fetch_rnd_ready", rnd_ready, 1);
    checkOutput("fetch_busy", busy, 1);
    checkOutput("fetch_din_ready", din_ready, 0);
    checkOutput("fetch_valid", sh_valid, 0);
    applyStimulus(1'b0, 4'h0, 1'b1, 8'h3C, 1'b1);
    tick();
    checkOutput("basic_f0", sh_f0, 32'h53);
    checkOutput("basic_f1", sh_f1, 32'h5C);
    checkOutput("basic_f2", sh_f2, 32'h3C);
    checkOutput("basic_valid", sh_valid, 1);
    checkOutput("basic_rnd_ready", rnd_ready, 0);
    checkOutput("basic_din_ready", din_ready, 1);
    checkOutput("basic_cnt_pre", sh_cnt, 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
    tick();
    exp_cnt = 1;
    checkOutput("basic_cnt", sh_cnt, exp_cnt);
    checkOutput("basic_idle_valid", sh_valid, 0);
    checkOutput("basic_idle_busy", busy, 0);
    checkOutput("basic_hold_f0", sh_f0, 32'h53);

    $display("[TB] randomness stall");
    applyStimulus(1'b1, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h7, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_rnd_ready", rnd_ready, 1);
      checkOutput("stall_valid", sh_valid, 0);
      checkOutput("stall_din_ready", din_ready, 0);
      checkOutput("stall_hold_f0", sh_f0, 32'h53);
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 8'hFF, 1'b0);
    tick();
    checkOutput("stall_f0", sh_f0, 32'h0F);
    checkOutput("stall_f1", sh_f1, 32'h0F);
    checkOutput("stall_f2", sh_f2, 32'hFF);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 4'h9, 1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("bp_f0", sh_f0, 32'h0F);
      checkOutput("bp_f1", sh_f1, 32'h0F);
      checkOutput("bp_f2", sh_f2, 32'hFF);
      checkOutput("bp_valid", sh_valid, 1);
      checkOutput("bp_din_ready", din_ready, 0);
      checkOutput("bp_rnd_ready", rnd_ready, 0);
      checkOutput("bp_cnt", sh_cnt, exp_cnt);
    end

    $display("[TB] streaming and narrow counter wrap");
    for (int i = 0; i < 14; i++) begin
      x = 4'(i * 5 + 3);
      r = 8'(i * 37 + 11);
      applyStimulus(1'b1, x, 1'b1, 8'hAA, 1'b1);
      tick();
      exp_cnt++;
      checkOutput("stream_cnt", sh_cnt, exp_cnt);
      checkOutput("stream_cnt4", sh_cnt4, exp_cnt % 16);
      checkOutput("stream_rnd_ready", rnd_ready, 1);
      checkOutput("stream_fetch_valid", sh_valid, 0);
      checkOutput("stream_fetch_din_ready", din_ready, 0);
      applyStimulus(1'b1, ~x, 1'b1, r, 1'b1);
      tick();
      checkOutput("stream_shares", {sh_f0, sh_f1, sh_f2}, model(x, r));
      checkOutput("stream_valid", sh_valid, 1);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
    tick();
    exp_cnt++;
    checkOutput("wrap_cnt16", sh_cnt, 16);
    checkOutput("wrap_cnt4", sh_cnt4, 0);
    checkOutput("wrap_busy", busy, 0);

    $display("[TB] exhaustive recombination");
    for (int xi = 0; xi < 16; xi++) begin
      for (int ri = 0; ri < 256; ri++) begin
        x = 4'(xi);
        r = 8'(ri);
        applyStimulus(1'b1, x, 1'b1, 8'h00, 1'b1);
        tick();
        if (rnd_ready) rr_count++;
        applyStimulus(1'b1, 4'h0, 1'b1, r, 1'b1);
        tick();
        if (rnd_ready) rr_count++;
        m = model(x, r);
        checkOutput("exh_shares", {sh_f0, sh_f1, sh_f2}, m);
        checkOutput("exh_recombine", sh_f0[7:4] ^ sh_f0[3:0] ^ sh_f1[3:0], x);
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
    tick();
    exp_cnt += 4096;
    checkOutput("exh_rnd_ready_once", rr_count, 4096);
    checkOutput("exh_cnt", sh_cnt, exp_cnt);
    checkOutput("exh_cnt4", sh_cnt4, exp_cnt % 16);

    $display("[TB] reset mid-FETCH");
    applyStimulus(1'b1, 4'h5, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b0, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_f0", sh_f0, 0);
    checkOutput("mid_rst_f1", sh_f1, 0);
    checkOutput("mid_rst_f2", sh_f2, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_rnd_ready", rnd_ready, 0);
    checkOutput("mid_rst_cnt", sh_cnt, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("post_rst_rnd_ready", rnd_ready, 0);
      checkOutput("post_rst_valid", sh_valid, 0);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_f0", sh_f0, 0);
      checkOutput("post_rst_cnt", sh_cnt, 0);
      checkOutput("post_rst_din_ready", din_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ti_share_gen.md
# ti_share_gen

Upstream masking stage for the first-order, three-share threshold-implementation 4-bit S-box. Accepts one unmasked nibble and one fresh 8-bit random word, splits the nibble into three Boolean shares, and drives three registered 8-bit share-pair buses. Each bus feeds one bank of 8-input component functions. Each bus omits exactly one share, which preserves non-completeness for the downstream component-function layer.

## Interface
Parameters:
- NIB_W, 4, nibble width; fixed, not to be overridden
- CNT_W, 16, width of issued-set counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  4  unmasked input nibble x
- din_valid  in  1  din qualifier
- din_ready  out  1  block can accept din this cycle
- rnd  in  8  fresh randomness; m0=rnd[3:0], m1=rnd[7:4]
- rnd_valid  in  1  rnd qualifier
- rnd_ready  out  1  block consumes rnd this cycle
- sh_f0  out  8  {s2,s1}, omits s0
- sh_f1  out  8  {s2,s0}, omits s1
- sh_f2  out  8  {s1,s0}, omits s2
- sh_valid  out  1  share buses hold a valid set
- sh_ready  in  1  downstream accepts the set
- busy  out  1  state != IDLE
- sh_cnt  out  CNT_W  number of share sets accepted downstream, wraps

## Operation
- Shares: s0=m0, s1=m1, s2=x^m0^m1. On each bus the higher-index share is in [7:4] and the lower-index share is in [3:0].
- FSM with states IDLE, FETCH, PRESENT. Reset state is IDLE.
- IDLE:
  - din_ready=1.
  - On din_valid: capture x into x_q, go to FETCH.
- FETCH:
  - rnd_ready=1, din_ready=0.
  - On rnd_valid: load s0/s1/s2 into the output registers, clear x_q to 0, go to PRESENT.
  - Without rnd_valid: stay in FETCH; x_q is held.
- PRESENT:
  - sh_valid=1; the buses hold stable until handshake completes.
  - On sh_ready: increment sh_cnt.
  - din_ready=sh_ready (combinational). If din_valid is also high, capture the new x and go to FETCH; otherwise go to IDLE.
  - Without sh_ready: stay; din_ready=0.
- Each rnd word is consumed exactly once. rnd_ready is asserted only in FETCH, and rnd is ignored in every other state.
- Share registers keep their last value after handshake; they are not zeroized. They change only on a FETCH→PRESENT load.
- No unmasked value ever appears on any output. x_q is the only register holding x.

## Timing
- Reset values:
  - sh_f0/f1/f2=0, sh_valid=0, rnd_ready=0, busy=0, sh_cnt=0.
  - din_ready=1 once rst is low.
  - x_q=0.
- Latency: din accepted in cycle t; rnd present in t+1; sh_valid=1 in t+2 with the new shares.
- Throughput: one nibble per 2 cycles with din_valid, rnd_valid and sh_ready held high (PRESENT→FETCH→PRESENT).
- sh_cnt wraps from 2^CNT_W−1 to 0.
- Reset mid-operation: all registers clear asynchronously; a pending x and any partially presented set are discarded; sh_cnt returns to 0.
- Simultaneous events:
  - rnd_valid in IDLE or PRESENT is ignored.
  - din_valid in FETCH is ignored (din_ready=0).

## Structure
- Shared package ti_pkg holds:
  - NIB_W=4 and NSHARES=3
  - state enum {IDLE, FETCH, PRESENT}
  - a share-pair packing helper that places the higher-index share in [7:4]
- One natural sub-module: ti_share_split, purely combinational (x, m0, m1 → s0, s1, s2), reused by later remasking stages. FSM, registers and counter stay in ti_share_gen.

## Test plan
- Basic split: x=0xA, rnd=0x3C, sh_ready=1 → in t+2: sh_f0=0x53, sh_f1=0x5C, sh_f2=0x3C, sh_valid=1; sh_cnt=1 after the handshake.
- Randomness stall: din accepted, rnd_valid held low for 5 cycles → stays in FETCH with rnd_ready=1, sh_valid=0; then rnd=0xFF with x=0x0 → s0=0xF, s1=0xF, s2=0x0.
- Back-pressure and streaming:
  - sh_ready low for 4 cycles → buses stable, din_ready=0.
  - Then continuous valids → one set every 2 cycles, sh_cnt increments by 1 per set.
- Reset mid-FETCH: rst pulsed between cycles → all outputs 0 immediately, FSM IDLE, later rnd_valid not consumed.
- Counter wrap: CNT_W=4, 16 sets issued → sh_cnt returns to 0.
- Exhaustive recombination: all 16 x × 256 rnd values → s0^s1^s2==x; each bus excludes its named share; rnd_ready asserted exactly once per set.
